// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - register command and ALU op codes shared with the control unit
package datapath_pkg;

    localparam logic [3:0] HOLD   = 4'd0;
    localparam logic [3:0] LOAD   = 4'd1;
    localparam logic [3:0] SHIFTR = 4'd2;
    localparam logic [3:0] SHIFTL = 4'd3;
    localparam logic [3:0] RESET  = 4'd4;

    localparam logic [3:0] ADD    = 4'd0;
    localparam logic [3:0] SUB    = 4'd1;
    localparam logic [3:0] MAIOR  = 4'd2;
    localparam logic [3:0] MENOR  = 4'd3;
    localparam logic [3:0] IGUAL  = 4'd4;
    localparam logic [3:0] XOR    = 4'd5;
    localparam logic [3:0] AND    = 4'd6;

endpackage

// File: rtl/datapath_reg_op.sv
// rtl/datapath_reg_op.sv - N-bit command-driven register (hold/load/shift/clear)
module reg_op
    import datapath_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [3:0]   i_cmd,
    input  logic [N-1:0] i_load,
    output logic [N-1:0] o_q
);

    logic [N-1:0] r_q;

    // Unassigned codes fall through to hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            case (i_cmd)
                LOAD:    r_q <= i_load;
                SHIFTR:  r_q <= {1'b0, r_q[N-1:1]};
                SHIFTL:  r_q <= {r_q[N-2:0], 1'b0};
                RESET:   r_q <= '0;
                default: r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/datapath.sv
// rtl/datapath.sv - X/Y/Z register datapath with ALU; DATAPATH_FLAGS_EN adds carry/zero flags
module datapath
    import datapath_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] data_in,
    input  logic [3:0]   Tx,
    input  logic [3:0]   Ty,
    input  logic [3:0]   Tz,
    input  logic [3:0]   Tula,
    output logic [N-1:0] X,
    output logic [N-1:0] Y,
    output logic [N-1:0] Z
`ifdef DATAPATH_FLAGS_EN
    ,
    output logic         flag_c,
    output logic         flag_z
`endif
);

    logic [N-1:0] w_x;
    logic [N-1:0] w_y;
    logic [N-1:0] w_z;
    logic [N-1:0] w_alu;
    logic [N:0]   w_sum;
    logic [N:0]   w_diff;
    logic         w_borrow;

    reg_op #(.N(N)) u_reg_x (.clock(clock), .reset(reset), .i_cmd(Tx), .i_load(data_in), .o_q(w_x));
    reg_op #(.N(N)) u_reg_y (.clock(clock), .reset(reset), .i_cmd(Ty), .i_load(w_x),     .o_q(w_y));
    reg_op #(.N(N)) u_reg_z (.clock(clock), .reset(reset), .i_cmd(Tz), .i_load(w_alu),   .o_q(w_z));

    // A = Y, B = X; compares are zero-extended to N bits.
    assign w_sum    = {1'b0, w_y} + {1'b0, w_x};
    assign w_diff   = {1'b0, w_y} - {1'b0, w_x};
    assign w_borrow = (w_y < w_x);

    always_comb begin
        w_alu = '0;
        case (Tula)
            ADD:     w_alu = w_sum[N-1:0];
            SUB:     w_alu = w_diff[N-1:0];
            MAIOR:   w_alu = {{(N-1){1'b0}}, (w_y > w_x)};
            MENOR:   w_alu = {{(N-1){1'b0}}, w_borrow};
            IGUAL:   w_alu = {{(N-1){1'b0}}, (w_y == w_x)};
            XOR:     w_alu = w_y ^ w_x;
            AND:     w_alu = w_y & w_x;
            default: w_alu = '0;
        endcase
    end

    assign X = w_x;
    assign Y = w_y;
    assign Z = w_z;

`ifdef DATAPATH_FLAGS_EN
    logic r_flag_c;
    logic r_flag_z;

    // Flags follow Z: captured on Tz=LOAD, cleared on Tz=RESET, held otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_flag_c <= 1'b0;
            r_flag_z <= 1'b0;
        end else if (Tz == LOAD) begin
            r_flag_c <= (Tula == ADD) ? w_sum[N] : ((Tula == SUB) ? w_borrow : 1'b0);
            r_flag_z <= (w_alu == '0);
        end else if (Tz == RESET) begin
            r_flag_c <= 1'b0;
            r_flag_z <= 1'b0;
        end
    end

    assign flag_c = r_flag_c;
    assign flag_z = r_flag_z;
`endif

endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - scoreboard bench for datapath
module tb_datapath;
    import datapath_pkg::*;

    localparam int N = 4;

    typedef struct packed {
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic [N-1:0] z;
        logic         c;
        logic         zf;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] data_in = '0;
    logic [3:0]   Tx = 4'd0;
    logic [3:0]   Ty = 4'd0;
    logic [3:0]   Tz = 4'd0;
    logic [3:0]   Tula = 4'd0;
    logic [N-1:0] X;
    logic [N-1:0] Y;
    logic [N-1:0] Z;
    logic         fc;
    logic         fz;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t sb[$];
    logic [N-1:0] mx = '0, my = '0, mz = '0;
    logic mc = 1'b0, mzf = 1'b0;

    datapath #(.N(N)) dut (
        .clock(clock), .reset(reset), .data_in(data_in),
        .Tx(Tx), .Ty(Ty), .Tz(Tz), .Tula(Tula),
        .X(X), .Y(Y), .Z(Z)
`ifdef DATAPATH_FLAGS_EN
        , .flag_c(fc), .flag_z(fz)
`endif
    );

`ifndef DATAPATH_FLAGS_EN
    assign fc = 1'b0;
    assign fz = 1'b0;
`endif

    always #5 clock = ~clock;

    function automatic logic [N-1:0] reg_next(input logic [N-1:0] q, input logic [3:0] c, input logic [N-1:0] d);
        if (c == 4'd1) return d;
        if (c == 4'd2) return q / 2;
        if (c == 4'd3) return (q * 2) % 16;
        if (c == 4'd4) return '0;
        return q;
    endfunction

    function automatic int alu_int(input int a, input int b, input int op);
        case (op)
            0: return (a + b) % 16;
            1: return (a - b + 16) % 16;
            2: return (a > b) ? 1 : 0;
            3: return (a < b) ? 1 : 0;
            4: return (a == b) ? 1 : 0;
            5: return a ^ b;
            6: return a & b;
            default: return 0;
        endcase
    endfunction

    // Drive one command word, advance the model, queue the post-edge expectation.
    task automatic step(input logic [N-1:0] d, input logic [3:0] tx, input logic [3:0] ty,
                        input logic [3:0] tz, input logic [3:0] op);
        exp_t e;
        int a, b, r;
        data_in = d; Tx = tx; Ty = ty; Tz = tz; Tula = op;
        a = int'(my); b = int'(mx);
        r = alu_int(a, b, int'(op));
        if (tz == 4'd1) begin
            mc  = (op == 4'd0) ? (a + b > 15) : ((op == 4'd1) ? (a < b) : 1'b0);
            mzf = (r == 0);
        end else if (tz == 4'd4) begin
            mc = 1'b0; mzf = 1'b0;
        end
        mz = reg_next(mz, tz, N'(r));
        my = reg_next(my, ty, mx);
        mx = reg_next(mx, tx, d);
        e = '{x: mx, y: my, z: mz, c: mc, zf: mzf};
        sb.push_back(e);
        @(posedge clock);
        #1;
        Tx = 4'd0; Ty = 4'd0; Tz = 4'd0; Tula = 4'd0;
    endtask

    task automatic test_reset;
        exp_t e;
        reset = 1'b1;
        #3;
        n_cmp++;
        if ({X, Y, Z, fc, fz} !== '0) begin
            n_bad++; $display("FAIL reset_init got %h/%h/%h c%b z%b want 0", X, Y, Z, fc, fz);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        step(4'd3, LOAD, HOLD, HOLD, ADD);
        step(4'd5, LOAD, LOAD, HOLD, ADD);
        step(4'd0, HOLD, HOLD, LOAD, ADD);
        while (sb.size() > 1) void'(sb.pop_front());
        e = sb.pop_front();
        n_cmp++;
        if (X !== e.x || Y !== e.y || Z !== e.z || {X, Y, Z} !== {4'd5, 4'd3, 4'd8}) begin
            n_bad++; $display("FAIL preload got %0d/%0d/%0d want 5/3/8", X, Y, Z);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({X, Y, Z, fc, fz} !== '0) begin
            n_bad++; $display("FAIL reset_async got %h/%h/%h c%b z%b want 0", X, Y, Z, fc, fz);
        end
        Tx = LOAD; data_in = 4'hF;
        @(posedge clock); #1;
        n_cmp++;
        if (X !== 4'd0) begin
            n_bad++; $display("FAIL reset_ignores_cmd got %0d want 0", X);
        end
        Tx = HOLD;
        mx = '0; my = '0; mz = '0; mc = 1'b0; mzf = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_load_chain;
        exp_t e;
        step(4'd2, LOAD, HOLD, HOLD, ADD);
        void'(sb.pop_front());
        step(4'd6, LOAD, LOAD, HOLD, ADD);
        e = sb.pop_front();
        n_cmp++;
        if (X !== e.x || Y !== e.y || X !== 4'd6 || Y !== 4'd2) begin
            n_bad++; $display("FAIL load_chain1 got X%0d Y%0d want X6 Y2", X, Y);
        end
        step(4'd0, HOLD, LOAD, HOLD, ADD);
        e = sb.pop_front();
        n_cmp++;
        if (Y !== e.y || Y !== 4'd6 || X !== 4'd6) begin
            n_bad++; $display("FAIL load_chain2 got X%0d Y%0d want X6 Y6", X, Y);
        end
    endtask

    task automatic test_alu;
        exp_t e;
        logic [3:0] ops  [8] = '{ADD, SUB, MAIOR, MENOR, IGUAL, XOR, AND, 4'd9};
        logic [3:0] want [8] = '{4'd13, 4'd5, 4'd1, 4'd0, 4'd0, 4'd13, 4'd0, 4'd0};
        step(4'd9, LOAD, HOLD, HOLD, ADD);
        step(4'd4, LOAD, LOAD, HOLD, ADD);
        sb.delete();
        for (int i = 0; i < 8; i++) begin
            step(4'd0, HOLD, HOLD, RESET, ADD);
            void'(sb.pop_front());
            step(4'd0, HOLD, HOLD, LOAD, ops[i]);
            e = sb.pop_front();
            n_cmp++;
            if (Z !== e.z || Z !== want[i] || X !== 4'd4 || Y !== 4'd9) begin
                n_bad++; $display("FAIL alu_op%0d got Z%0d want Z%0d", ops[i], Z, want[i]);
            end
        end
    endtask

    task automatic test_shift;
        exp_t e;
        step(4'b1011, LOAD, HOLD, HOLD, ADD);
        void'(sb.pop_front());
        step(4'd0, SHIFTR, HOLD, HOLD, ADD);
        e = sb.pop_front();
        n_cmp++;
        if (X !== e.x || X !== 4'b0101) begin
            n_bad++; $display("FAIL shiftr got %b want 0101", X);
        end
        step(4'd0, SHIFTL, HOLD, HOLD, ADD);
        e = sb.pop_front();
        n_cmp++;
        if (X !== e.x || X !== 4'b1010) begin
            n_bad++; $display("FAIL shiftl got %b want 1010", X);
        end
        step(4'd0, HOLD, HOLD, LOAD, XOR);
        void'(sb.pop_front());
        step(4'd0, HOLD, HOLD, RESET, ADD);
        e = sb.pop_front();
        n_cmp++;
        if (Z !== e.z || Z !== 4'd0 || fc !== 1'b0 || fz !== 1'b0) begin
            n_bad++; $display("FAIL tz_reset got Z%0d c%b z%b want 0", Z, fc, fz);
        end
        step(4'hF, 4'd7, HOLD, HOLD, ADD);
        e = sb.pop_front();
        n_cmp++;
        if (X !== e.x || X !== 4'b1010) begin
            n_bad++; $display("FAIL tx7_hold got %b want 1010", X);
        end
    endtask

    task automatic test_flags;
        exp_t e;
        step(4'd12, LOAD, HOLD, HOLD, ADD);
        step(4'd4, LOAD, LOAD, HOLD, ADD);
        sb.delete();
        step(4'd0, HOLD, HOLD, LOAD, ADD);
        e = sb.pop_front();
        n_cmp++;
        if (Z !== 4'd0 || fc !== 1'b1 || fz !== 1'b1 || fc !== e.c) begin
            n_bad++; $display("FAIL flags_add got Z%0d c%b z%b want Z0 c1 z1", Z, fc, fz);
        end
        step(4'd0, HOLD, HOLD, HOLD, SUB);
        e = sb.pop_front();
        n_cmp++;
        if (fc !== 1'b1 || fz !== 1'b1) begin
            n_bad++; $display("FAIL flags_hold got c%b z%b want c1 z1", fc, fz);
        end
        step(4'd2, LOAD, HOLD, HOLD, ADD);
        step(4'd3, LOAD, LOAD, HOLD, ADD);
        sb.delete();
        step(4'd0, HOLD, HOLD, LOAD, SUB);
        e = sb.pop_front();
        n_cmp++;
        if (Z !== 4'd15 || fc !== 1'b1 || fz !== 1'b0 || fz !== e.zf) begin
            n_bad++; $display("FAIL flags_sub got Z%0d c%b z%b want Z15 c1 z0", Z, fc, fz);
        end
        step(4'd0, HOLD, HOLD, RESET, ADD);
        e = sb.pop_front();
        n_cmp++;
        if (fc !== 1'b0 || fz !== 1'b0) begin
            n_bad++; $display("FAIL flags_clear got c%b z%b want 0", fc, fz);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int bad = 0;
        for (int i = 0; i < 60; i++) begin
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                 4'($urandom_range(0, 7)), 4'($urandom_range(0, 9)));
            e = sb.pop_front();
            n_cmp++;
            if (X !== e.x || Y !== e.y || Z !== e.z
`ifdef DATAPATH_FLAGS_EN
                || fc !== e.c || fz !== e.zf
`endif
            ) begin
                n_bad++;
                if (bad < 5) $display("FAIL random%0d got %h/%h/%h c%b z%b want %h/%h/%h c%b z%b",
                                      i, X, Y, Z, fc, fz, e.x, e.y, e.z, e.c, e.zf);
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_chain();
        test_alu();
        test_shift();
`ifdef DATAPATH_FLAGS_EN
        test_flags();
`endif
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
